// File: rtl/iq_stream_slicer.sv
// Splits interleaved I/Q stream beats into packed I and Q lane buses through a
// 2-entry elastic buffer, with per-beat transform modes and drop/beat statistics.
module iq_stream_slicer #(
   parameter int SAMPLE_W  = 16,
   parameter int NUM_PAIRS = 8,
   parameter int CNT_W     = 32,
   parameter int DROP_W    = 16
) (
   input  logic                            clock,
   input  logic                            resetn,
   input  logic [2*SAMPLE_W*NUM_PAIRS-1:0] s_tdata,
   input  logic                            s_tvalid,
   output logic                            s_tready,
   input  logic [1:0]                      mode,
   output logic [SAMPLE_W*NUM_PAIRS-1:0]   m_i_data,
   output logic [SAMPLE_W*NUM_PAIRS-1:0]   m_q_data,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   input  logic                            clear_stats,
   output logic [CNT_W-1:0]                beat_count,
   output logic [DROP_W-1:0]               drop_count,
   output logic                            overflow
);

   localparam int LANE_W = SAMPLE_W * NUM_PAIRS;
   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_SWAP = 2'd1;
   localparam logic [1:0] MODE_CONJ = 2'd2;
   localparam logic [SAMPLE_W-1:0] S_MIN  = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0] S_MAX  = ~S_MIN;
   localparam logic [SAMPLE_W-1:0] S_ZERO = '0;

   // Handshakes: a beat moves on either side only when valid and ready are both
   // high at a rising edge; s_tready never depends on s_tvalid.
   logic [1:0]        count_q, count_d;
   logic [LANE_W-1:0] head_i_q, head_i_d, head_q_q, head_q_d;
   logic [LANE_W-1:0] tail_i_q, tail_i_d, tail_q_q, tail_q_d;
   logic [CNT_W-1:0]  beat_count_q, beat_count_d;
   logic [DROP_W-1:0] drop_count_q, drop_count_d;
   logic              overflow_q, overflow_d;

   logic              push, pop, drop;
   logic [LANE_W-1:0] xf_i, xf_q;
   logic [SAMPLE_W-1:0] w_i, w_q;

   assign s_tready = resetn && (count_q != 2'd2);
   assign push     = s_tvalid && s_tready;
   assign pop      = (count_q != 2'd0) && m_tready;
   assign drop     = resetn && s_tvalid && !s_tready;

   // Transform at push time so the mode travels with the beat it was sampled on.
   always_comb begin
      xf_i = '0;
      xf_q = '0;
      w_i  = '0;
      w_q  = '0;
      for (int k = 0; k < NUM_PAIRS; k++) begin
         w_i = s_tdata[2*k*SAMPLE_W +: SAMPLE_W];
         w_q = s_tdata[(2*k+1)*SAMPLE_W +: SAMPLE_W];
         case (mode)
            MODE_PASS: begin
               xf_i[k*SAMPLE_W +: SAMPLE_W] = w_i;
               xf_q[k*SAMPLE_W +: SAMPLE_W] = w_q;
            end
            MODE_SWAP: begin
               xf_i[k*SAMPLE_W +: SAMPLE_W] = w_q;
               xf_q[k*SAMPLE_W +: SAMPLE_W] = w_i;
            end
            MODE_CONJ: begin
               xf_i[k*SAMPLE_W +: SAMPLE_W] = w_i;
               xf_q[k*SAMPLE_W +: SAMPLE_W] = (w_q == S_MIN) ? S_MAX : (S_ZERO - w_q);
            end
            default: begin
               xf_i[k*SAMPLE_W +: SAMPLE_W] = w_i;
               xf_q[k*SAMPLE_W +: SAMPLE_W] = S_ZERO;
            end
         endcase
      end
   end

   // Head register drives the outputs directly; it is only overwritten by new
   // data, so the last beat stays visible when the buffer drains.
   always_comb begin
      count_d  = count_q;
      head_i_d = head_i_q;
      head_q_d = head_q_q;
      tail_i_d = tail_i_q;
      tail_q_d = tail_q_q;
      case ({push, pop})
         2'b10: begin
            count_d = count_q + 2'd1;
            if (count_q == 2'd0) begin
               head_i_d = xf_i;
               head_q_d = xf_q;
            end else begin
               tail_i_d = xf_i;
               tail_q_d = xf_q;
            end
         end
         2'b01: begin
            count_d = count_q - 2'd1;
            if (count_q == 2'd2) begin
               head_i_d = tail_i_q;
               head_q_d = tail_q_q;
            end
         end
         2'b11: begin
            head_i_d = xf_i;
            head_q_d = xf_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      beat_count_d = beat_count_q;
      drop_count_d = drop_count_q;
      overflow_d   = overflow_q;
      if (clear_stats) begin
         beat_count_d = '0;
         drop_count_d = '0;
         overflow_d   = 1'b0;
      end else begin
         if (push) beat_count_d = beat_count_q + CNT_W'(1);
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != {DROP_W{1'b1}}) drop_count_d = drop_count_q + DROP_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         count_q      <= 2'd0;
         head_i_q     <= '0;
         head_q_q     <= '0;
         tail_i_q     <= '0;
         tail_q_q     <= '0;
         beat_count_q <= '0;
         drop_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         count_q      <= count_d;
         head_i_q     <= head_i_d;
         head_q_q     <= head_q_d;
         tail_i_q     <= tail_i_d;
         tail_q_q     <= tail_q_d;
         beat_count_q <= beat_count_d;
         drop_count_q <= drop_count_d;
         overflow_q   <= overflow_d;
      end
   end

   assign m_tvalid   = (count_q != 2'd0);
   assign m_i_data   = head_i_q;
   assign m_q_data   = head_q_q;
   assign beat_count = beat_count_q;
   assign drop_count = drop_count_q;
   assign overflow   = overflow_q;

endmodule
